led_digit_scan: RTL and testbench

Multiplexed three-digit seven-segment scanner for the no-RAM LED display path. It sits directly downstream of the binary-to-BCD converter. It captures the 12-bit packed BCD value `{hundreds, tens, ones}` and time-multiplexes it onto one shared segment bus with three digit enables. Updates are tear-free: a new value takes effect only at a frame boundary. A dead-time gap between digits prevents ghosting.

---
 rtl/led_pkg.sv | 27 ++
 rtl/seg_decode.sv | 18 +
 rtl/led_digit_scan.sv | 155 +++++++++++++++
 tb/tb_led_digit_scan.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner:
// active-low segment patterns, scan state encoding and packed-BCD layout.
package led_pkg;

    // Active-low {g,f,e,d,c,b,a} patterns.
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    // Digit table, entry N is the pattern for decimal digit N.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // GAP: dead time with every output off. DRIVE: selected digit lit.
    typedef enum logic {
        GAP   = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    // Packed-BCD field layout {hundreds, tens, ones}.
    localparam int BCD_DIGIT_W  = 4;
    localparam int BCD_ONES_LSB = 0;
    localparam int BCD_TENS_LSB = 4;
    localparam int BCD_HUND_LSB = 8;

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Nibbles 10..15 are not decimal and show a dash.
module seg_decode
    import led_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // Table lookup for decimal digits, dash for everything else.
    always_comb begin
        seg_o = SEG_DASH;
        if (nib_i <= 4'd9) begin
            seg_o = SEG_DIGIT[nib_i];
        end
    end

endmodule

// File: rtl/led_digit_scan.sv
// Three-digit multiplexed seven-segment scanner.
// Captures packed BCD on load and shows it tear-free from the next frame
// boundary; each digit slot opens with a dead-time gap against ghosting.
// Optional build macro: LED_ZERO_BLANK_EN enables leading-zero blanking.
module led_digit_scan
    import led_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] dec,
    input  logic        load,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        busy
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GAP_LAST = CNT_W'(DEAD_CYCLES - 1);

    logic [11:0]      shown_q, shown_d;
    logic [11:0]      pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    scan_state_e      state_q, state_d;
    logic [6:0]       seg_q, seg_d;
    logic [2:0]       an_q, an_d;

    logic             slot_end;
    logic             frame_end;
    logic [3:0]       digit_nib;
    logic [6:0]       digit_seg;
    logic             digit_blank;

    logic [3:0]       ones_nib;
    logic [3:0]       tens_nib;
    logic [3:0]       hund_nib;

    assign ones_nib  = shown_q[BCD_ONES_LSB +: BCD_DIGIT_W];
    assign tens_nib  = shown_q[BCD_TENS_LSB +: BCD_DIGIT_W];
    assign hund_nib  = shown_q[BCD_HUND_LSB +: BCD_DIGIT_W];

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == 2'd2);

    // Select the nibble of the digit currently being scanned.
    always_comb begin
        digit_nib = ones_nib;
        case (idx_q)
            2'd1:    digit_nib = tens_nib;
            2'd2:    digit_nib = hund_nib;
            default: digit_nib = ones_nib;
        endcase
    end

    // One decoder shared by all three digits through the idx mux.
    seg_decode u_seg_decode (
        .nib_i (digit_nib),
        .seg_o (digit_seg)
    );

`ifdef LED_ZERO_BLANK_EN
    // Leading zeros stay dark; the ones digit is always shown.
    always_comb begin
        digit_blank = 1'b0;
        case (idx_q)
            2'd1:    digit_blank = (hund_nib == 4'd0) && (tens_nib == 4'd0);
            2'd2:    digit_blank = (hund_nib == 4'd0);
            2'd3:    digit_blank = 1'b1;
            default: digit_blank = 1'b0;
        endcase
    end
`else
    // Every real digit is driven; the unused index 3 stays dark.
    always_comb begin
        digit_blank = (idx_q == 2'd3);
    end
`endif

    // Next-state for scan timing, load capture and registered outputs.
    always_comb begin
        shown_d  = shown_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        idx_d    = idx_q;
        state_d  = state_q;
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        seg_d    = SEG_OFF;
        an_d     = 3'b111;

        if (slot_end) begin
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end

        case (state_q)
            GAP:     if (cnt_q == CNT_GAP_LAST) state_d = DRIVE;
            DRIVE:   if (slot_end)              state_d = GAP;
            default: state_d = GAP;
        endcase

        // Last load wins until the frame boundary commits it.
        if (load) begin
            pend_d   = dec;
            pend_v_d = 1'b1;
        end

        // A load on the boundary cycle itself bypasses the pending slot.
        if (frame_end) begin
            if (load) begin
                shown_d  = dec;
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                shown_d  = pend_q;
                pend_v_d = 1'b0;
            end
        end

        if ((state_q == DRIVE) && !digit_blank) begin
            seg_d = digit_seg;
            an_d  = ~(3'b001 << idx_q);
        end
    end

    // Single state register for the scan FSM, datapath and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            shown_q  <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            idx_q    <= 2'd0;
            cnt_q    <= '0;
            state_q  <= GAP;
            seg_q    <= SEG_OFF;
            an_q     <= 3'b111;
        end else begin
            shown_q  <= shown_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = pend_v_q;

endmodule

// File: tb/tb_led_digit_scan.sv
// Directed testbench for led_digit_scan with SCAN_DIV=8, DEAD_CYCLES=2.
// cyc counts clock intervals since the last reset edge; slot k of a frame
// appears on the outputs during intervals 24f + 8k + 1 .. 24f + 8k + 8.
module tb_led_digit_scan;

    localparam int SCAN_DIV    = 8;
    localparam int DEAD_CYCLES = 2;
`ifdef LED_ZERO_BLANK_EN
    localparam bit ZB = 1'b1;
`else
    localparam bit ZB = 1'b0;
`endif

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        load = 1'b0;
    logic [11:0] dec  = 12'h000;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    led_digit_scan #(
        .SCAN_DIV    (SCAN_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .dec  (dec),
        .load (load),
        .seg  (seg),
        .an   (an),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto_cyc(input int t);
        while (cyc < t) tick();
    endtask

    task automatic do_load(input logic [11:0] d);
        dec  = d;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic check_slot(input string tag, input logic [2:0] exp_an, input logic [6:0] exp_seg);
        for (int i = 0; i < SCAN_DIV; i++) begin
            if (i < DEAD_CYCLES) begin
                chk({tag, "_gap_an"}, 32'(an), 32'(3'b111));
                chk({tag, "_gap_seg"}, 32'(seg), 32'(7'h7F));
            end else begin
                chk({tag, "_an"}, 32'(an), 32'(exp_an));
                chk({tag, "_seg"}, 32'(seg), 32'(exp_seg));
            end
            tick();
        end
    endtask

    initial begin
        // Reset held for 48 cycles: everything dark and idle.
        rst = 1'b1;
        for (int i = 0; i < 48; i++) begin
            @(posedge clk);
            #1;
            chk("rst_seg", 32'(seg), 32'(7'h7F));
            chk("rst_an", 32'(an), 32'(3'b111));
            chk("rst_busy", 32'(busy), 32'd0);
        end
        rst = 1'b0;
        cyc = 0;
        chk("rel_seg", 32'(seg), 32'(7'h7F));
        chk("rel_an", 32'(an), 32'(3'b111));
        chk("rel_busy", 32'(busy), 32'd0);

        // shown=0 after reset: ones shows 0.
        tick();
        check_slot("zero_ones", 3'b110, 7'h40);

        // Load 123 mid-frame; old value holds until the boundary.
        goto_cyc(10);
        do_load(12'h123);
        chk("busy_123", 32'(busy), 32'd1);
        goto_cyc(17);
        chk("busy_123_hold", 32'(busy), 32'd1);
        check_slot("old_hund", ZB ? 3'b111 : 3'b011, ZB ? 7'h7F : 7'h40);
        chk("busy_123_done", 32'(busy), 32'd0);
        check_slot("v123_ones", 3'b110, 7'h30);
        check_slot("v123_tens", 3'b101, 7'h24);
        check_slot("v123_hund", 3'b011, 7'h79);

        // 007: leading-zero blanking depends on the build.
        do_load(12'h007);
        chk("busy_007", 32'(busy), 32'd1);
        goto_cyc(73);
        check_slot("v007_ones", 3'b110, 7'h78);
        check_slot("v007_tens", ZB ? 3'b111 : 3'b101, ZB ? 7'h7F : 7'h40);
        check_slot("v007_hund", ZB ? 3'b111 : 3'b011, ZB ? 7'h7F : 7'h40);

        // 456 overwritten by 789 before the boundary.
        goto_cyc(100);
        do_load(12'h456);
        goto_cyc(105);
        do_load(12'h789);
        while (cyc < 120) begin
            chk("busy_789_pend", 32'(busy), 32'd1);
            tick();
        end
        chk("busy_789_done", 32'(busy), 32'd0);
        tick();
        check_slot("v789_ones", 3'b110, 7'h10);
        check_slot("v789_tens", 3'b101, 7'h00);
        check_slot("v789_hund", 3'b011, 7'h78);

        // A0F loaded exactly on the boundary cycle.
        goto_cyc(167);
        chk("busy_pre_a0f", 32'(busy), 32'd0);
        do_load(12'hA0F);
        chk("busy_a0f", 32'(busy), 32'd0);
        tick();
        check_slot("va0f_ones", 3'b110, 7'h3F);
        check_slot("va0f_tens", 3'b101, 7'h40);
        check_slot("va0f_hund", 3'b011, 7'h3F);
        chk("busy_a0f_end", 32'(busy), 32'd0);

        // Reset during DRIVE with a pending load discards it.
        goto_cyc(194);
        do_load(12'h123);
        chk("busy_pre_rst", 32'(busy), 32'd1);
        goto_cyc(203);
        rst = 1'b1;
        tick();
        chk("mid_rst_seg", 32'(seg), 32'(7'h7F));
        chk("mid_rst_an", 32'(an), 32'(3'b111));
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        cyc = 0;
        tick();
        check_slot("post_rst_ones", 3'b110, 7'h40);
        check_slot("post_rst_tens", ZB ? 3'b111 : 3'b101, ZB ? 7'h7F : 7'h40);
        goto_cyc(25);
        chk("post_rst_busy", 32'(busy), 32'd0);
        check_slot("post_rst_ones2", 3'b110, 7'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
